// File: rtl/lcd_pkg.sv
// Shared constants for the HD44780-style 4-bit bus receiver: command codes,
// DDRAM line bases, default fill character and FSM state encoding.
package lcd_pkg;

    localparam logic [7:0] CMD_CLEAR      = 8'h01;
    localparam logic [7:0] CMD_HOME       = 8'h02;
    localparam logic [7:0] CMD_HOME_MASK  = 8'hFE;
    localparam logic [7:0] CMD_ENTRY      = 8'h04;
    localparam logic [7:0] CMD_ENTRY_MASK = 8'hFC;
    localparam logic [7:0] CMD_DDRAM_MASK = 8'h80;

    localparam logic [6:0] LINE1_BASE = 7'h00;
    localparam logic [6:0] LINE2_BASE = 7'h40;

    localparam logic [7:0] DEF_CLEAR_CHAR = 8'h20;

    localparam logic [1:0] ST_BOOT8 = 2'd0;
    localparam logic [1:0] ST_HI    = 2'd1;
    localparam logic [1:0] ST_LO    = 2'd2;

    // 0x40..0x4F lands on line 2; everything else folds onto line 1 by a[3:0].
    function automatic logic [4:0] ddram_index(input logic [6:0] a);
        if (a[6:4] == LINE2_BASE[6:4])
            return {1'b1, a[3:0]};
        else
            return {1'b0, a[3:0]};
    endfunction

endpackage

// File: rtl/lcd_nibble_sync.sv
// Two-flop synchronizer for the asynchronous LCD bus plus an E falling-edge
// detector; rs/rw/nibble are captured from the synchronized stage at the fall.
module lcd_nibble_sync (
    input  logic       clk,
    input  logic       rst,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic       lcd_e,
    input  logic       lcd_4,
    input  logic       lcd_5,
    input  logic       lcd_6,
    input  logic       lcd_7,
    output logic       fall,
    output logic       rs,
    output logic       rw,
    output logic [3:0] nib
);

    logic [6:0] raw;
    logic [6:0] s1;
    logic [6:0] s2;
    logic       e_d;
    logic       e_fall;

    assign raw    = {lcd_e, lcd_rs, lcd_rw, lcd_7, lcd_6, lcd_5, lcd_4};
    assign e_fall = e_d & ~s2[6];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1   <= '0;
            s2   <= '0;
            e_d  <= 1'b0;
            fall <= 1'b0;
            rs   <= 1'b0;
            rw   <= 1'b0;
            nib  <= '0;
        end else begin
            s1   <= raw;
            s2   <= s1;
            e_d  <= s2[6];
            fall <= e_fall;
            if (e_fall)
                {rs, rw, nib} <= s2[5:0];
        end
    end

endmodule

// File: rtl/lcd_bus_rx.sv
// Far-end decoder for the 4-bit LCD bus: tracks 8-bit init, pairs nibbles into
// bytes, executes display commands and rebuilds the 32-char display image.
module lcd_bus_rx
    import lcd_pkg::*;
#(
    parameter int         NIBBLE_TIMEOUT = 50000,
    parameter logic [7:0] CLEAR_CHAR     = DEF_CLEAR_CHAR
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         lcd_rs,
    input  logic         lcd_rw,
    input  logic         lcd_e,
    input  logic         lcd_4,
    input  logic         lcd_5,
    input  logic         lcd_6,
    input  logic         lcd_7,
    output logic [255:0] chars,
    output logic         byte_valid,
    output logic [7:0]   byte_data,
    output logic         byte_rs,
    output logic         mode4,
    output logic [4:0]   cursor,
    output logic         sync_err
);

    localparam int               CNT_W  = $clog2(NIBBLE_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(NIBBLE_TIMEOUT);

    logic             fall;
    logic             s_rs;
    logic             s_rw;
    logic [3:0]       s_nib;
    logic             fire;
    logic [1:0]       state;
    logic [3:0]       hi_nib;
    logic             hi_rs;
    logic [CNT_W-1:0] cnt;
    logic             incr;
    logic [31:0][7:0] img;
    logic [7:0]       rx_byte;

    lcd_nibble_sync u_sync (
        .clk    (clk),
        .rst    (rst),
        .lcd_rs (lcd_rs),
        .lcd_rw (lcd_rw),
        .lcd_e  (lcd_e),
        .lcd_4  (lcd_4),
        .lcd_5  (lcd_5),
        .lcd_6  (lcd_6),
        .lcd_7  (lcd_7),
        .fall   (fall),
        .rs     (s_rs),
        .rw     (s_rw),
        .nib    (s_nib)
    );

    // Reads are invisible to the receiver: they never advance the nibble phase.
    assign fire     = fall & ~s_rw;
    assign rx_byte  = {hi_nib, s_nib};
    assign sync_err = (state == ST_LO) && !fire && (cnt == TO_VAL);

    for (genvar i = 0; i < 32; i++) begin : g_img
        assign chars[255-8*i -: 8] = img[i];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_BOOT8;
            hi_nib     <= '0;
            hi_rs      <= 1'b0;
            cnt        <= '0;
            incr       <= 1'b1;
            img        <= {32{CLEAR_CHAR}};
            cursor     <= '0;
            mode4      <= 1'b0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
            byte_rs    <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            case (state)
                ST_BOOT8: begin
                    if (fire && s_nib == 4'h2 && !s_rs) begin
                        mode4 <= 1'b1;
                        state <= ST_HI;
                    end
                end
                ST_HI: begin
                    if (fire) begin
                        hi_nib <= s_nib;
                        hi_rs  <= s_rs;
                        cnt    <= '0;
                        state  <= ST_LO;
                    end
                end
                ST_LO: begin
                    if (fire) begin
                        state      <= ST_HI;
                        cnt        <= '0;
                        byte_valid <= 1'b1;
                        byte_data  <= rx_byte;
                        byte_rs    <= hi_rs;
                        if (hi_rs) begin
                            img[cursor] <= rx_byte;
                            cursor      <= incr ? cursor + 5'd1 : cursor - 5'd1;
                        end else if (rx_byte == CMD_CLEAR) begin
                            img    <= {32{CLEAR_CHAR}};
                            cursor <= '0;
                            incr   <= 1'b1;
                        end else if ((rx_byte & CMD_HOME_MASK) == CMD_HOME) begin
                            cursor <= '0;
                        end else if ((rx_byte & CMD_ENTRY_MASK) == CMD_ENTRY) begin
                            incr <= rx_byte[1];
                        end else if ((rx_byte & CMD_DDRAM_MASK) != 8'h00) begin
                            cursor <= ddram_index(rx_byte[6:0]);
                        end
                    end else if (cnt == TO_VAL) begin
                        state <= ST_HI;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= ST_BOOT8;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_bus_rx.sv
// Directed bench for lcd_bus_rx: init, commands, data, wrap, timeout, reset.
module tb_lcd_bus_rx;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         lcd_rs = 1'b0, lcd_rw = 1'b0, lcd_e = 1'b0;
    logic         lcd_4 = 1'b0, lcd_5 = 1'b0, lcd_6 = 1'b0, lcd_7 = 1'b0;
    logic [255:0] chars;
    logic         byte_valid, byte_rs, mode4, sync_err;
    logic [7:0]   byte_data;
    logic [4:0]   cursor;

    int checks = 0;
    int passed = 0;
    int bv_cnt = 0;
    int se_cnt = 0;
    logic [255:0] blank;

    always #10 clk = ~clk;

    lcd_bus_rx dut (
        .clk(clk), .rst(rst),
        .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e),
        .lcd_4(lcd_4), .lcd_5(lcd_5), .lcd_6(lcd_6), .lcd_7(lcd_7),
        .chars(chars), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_rs(byte_rs), .mode4(mode4), .cursor(cursor), .sync_err(sync_err)
    );

    always @(posedge clk) begin
        if (byte_valid) bv_cnt <= bv_cnt + 1;
        if (sync_err)   se_cnt <= se_cnt + 1;
    end

    // One E strobe; lat = posedges from E fall to first byte_valid (0 = none).
    task automatic strobe(input logic rs, input logic rw, input logic [3:0] n, output int lat);
        @(negedge clk);
        lcd_rs = rs; lcd_rw = rw; {lcd_7, lcd_6, lcd_5, lcd_4} = n;
        repeat (3) @(negedge clk);
        lcd_e = 1'b1;
        repeat (12) @(negedge clk);
        lcd_e = 1'b0;
        lat = 0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            if (byte_valid && lat == 0) lat = i;
        end
    endtask

    task automatic send_byte(input logic rs, input logic [7:0] b, output int lat);
        int l0;
        strobe(rs, 1'b0, b[7:4], l0);
        strobe(rs, 1'b0, b[3:0], lat);
    endtask

    task automatic test_reset;
        checks++; if (chars !== blank) $display("FAIL reset_chars got %h want %h", chars, blank); else passed++;
        checks++; if (cursor !== 5'd0) $display("FAIL reset_cursor got %0d want 0", cursor); else passed++;
        checks++; if (mode4 !== 1'b0) $display("FAIL reset_mode4 got %b want 0", mode4); else passed++;
        checks++; if (byte_valid !== 1'b0 || sync_err !== 1'b0) $display("FAIL reset_pulses got bv=%b se=%b want 0 0", byte_valid, sync_err); else passed++;
        checks++; if (byte_data !== 8'h00 || byte_rs !== 1'b0) $display("FAIL reset_byte got %h/%b want 00/0", byte_data, byte_rs); else passed++;
    endtask

    task automatic test_init;
        int l;
        int bv0;
        bv0 = bv_cnt;
        strobe(1'b0, 1'b0, 4'h3, l);
        strobe(1'b0, 1'b0, 4'h3, l);
        strobe(1'b0, 1'b0, 4'h3, l);
        checks++; if (mode4 !== 1'b0) $display("FAIL init_mode4_early got %b want 0", mode4); else passed++;
        strobe(1'b0, 1'b0, 4'h2, l);
        checks++; if (mode4 !== 1'b1) $display("FAIL init_mode4 got %b want 1", mode4); else passed++;
        checks++; if (bv_cnt !== bv0) $display("FAIL init_no_bytes got %0d want %0d", bv_cnt, bv0); else passed++;
    endtask

    task automatic test_setup_clear;
        int l;
        int bv0;
        bv0 = bv_cnt;
        send_byte(1'b0, 8'h28, l);
        send_byte(1'b0, 8'h0C, l);
        send_byte(1'b0, 8'h06, l);
        send_byte(1'b1, 8'h55, l);
        checks++; if (chars[255:248] !== 8'h55 || cursor !== 5'd1) $display("FAIL pre_clear got %h cur %0d want 55 cur 1", chars[255:248], cursor); else passed++;
        send_byte(1'b0, 8'h01, l);
        checks++; if (bv_cnt !== bv0 + 5) $display("FAIL setup_byte_count got %0d want %0d", bv_cnt, bv0 + 5); else passed++;
        checks++; if (chars !== blank) $display("FAIL clear_chars got %h want %h", chars, blank); else passed++;
        checks++; if (cursor !== 5'd0) $display("FAIL clear_cursor got %0d want 0", cursor); else passed++;
        checks++; if (byte_data !== 8'h01 || byte_rs !== 1'b0) $display("FAIL clear_byte got %h/%b want 01/0", byte_data, byte_rs); else passed++;
    endtask

    task automatic test_data_write;
        int l;
        send_byte(1'b1, 8'h48, l);
        checks++; if (l !== 4) $display("FAIL data_latency0 got %0d want 4", l); else passed++;
        send_byte(1'b1, 8'h65, l);
        checks++; if (l !== 4) $display("FAIL data_latency1 got %0d want 4", l); else passed++;
        checks++; if (chars[255:240] !== 16'h4865) $display("FAIL data_chars got %h want 4865", chars[255:240]); else passed++;
        checks++; if (cursor !== 5'd2) $display("FAIL data_cursor got %0d want 2", cursor); else passed++;
        checks++; if (byte_rs !== 1'b1 || byte_data !== 8'h65) $display("FAIL data_byte got %h/%b want 65/1", byte_data, byte_rs); else passed++;
    endtask

    task automatic test_rw_ignored;
        int l;
        int bv0;
        bv0 = bv_cnt;
        strobe(1'b1, 1'b0, 4'h6, l);
        strobe(1'b1, 1'b1, 4'h9, l);
        checks++; if (bv_cnt !== bv0) $display("FAIL rw_no_byte got %0d want %0d", bv_cnt, bv0); else passed++;
        strobe(1'b1, 1'b0, 4'h1, l);
        checks++; if (byte_data !== 8'h61 || bv_cnt !== bv0 + 1) $display("FAIL rw_pair got %h n=%0d want 61 n=%0d", byte_data, bv_cnt, bv0 + 1); else passed++;
        checks++; if (chars[239:232] !== 8'h61 || cursor !== 5'd3) $display("FAIL rw_write got %h cur %0d want 61 cur 3", chars[239:232], cursor); else passed++;
    endtask

    task automatic test_line2_wrap;
        int l;
        send_byte(1'b0, 8'hC0, l);
        checks++; if (cursor !== 5'd16) $display("FAIL line2_addr got %0d want 16", cursor); else passed++;
        send_byte(1'b1, 8'h35, l);
        checks++; if (chars[127:120] !== 8'h35 || cursor !== 5'd17) $display("FAIL line2_data got %h cur %0d want 35 cur 17", chars[127:120], cursor); else passed++;
        send_byte(1'b0, 8'h9F, l);
        checks++; if (cursor !== 5'd15) $display("FAIL other_addr got %0d want 15", cursor); else passed++;
        send_byte(1'b0, 8'hCF, l);
        checks++; if (cursor !== 5'd31) $display("FAIL last_addr got %0d want 31", cursor); else passed++;
        send_byte(1'b1, 8'h41, l);
        checks++; if (chars[7:0] !== 8'h41 || cursor !== 5'd0) $display("FAIL wrap_inc got %h cur %0d want 41 cur 0", chars[7:0], cursor); else passed++;
        send_byte(1'b0, 8'h04, l);
        send_byte(1'b1, 8'h5A, l);
        checks++; if (chars[255:248] !== 8'h5A || cursor !== 5'd31) $display("FAIL wrap_dec got %h cur %0d want 5a cur 31", chars[255:248], cursor); else passed++;
        send_byte(1'b0, 8'h06, l);
        send_byte(1'b0, 8'h02, l);
        checks++; if (cursor !== 5'd0) $display("FAIL home got %0d want 0", cursor); else passed++;
    endtask

    task automatic test_timeout;
        int l;
        int se0;
        se0 = se_cnt;
        strobe(1'b0, 1'b0, 4'h7, l);
        repeat (49990) @(posedge clk);
        #1;
        checks++; if (se_cnt !== se0) $display("FAIL timeout_early got %0d want %0d", se_cnt - se0, 0); else passed++;
        repeat (20) @(posedge clk);
        #1;
        checks++; if (se_cnt !== se0 + 1) $display("FAIL timeout_pulse got %0d want 1", se_cnt - se0); else passed++;
        strobe(1'b1, 1'b0, 4'h4, l);
        strobe(1'b1, 1'b0, 4'h1, l);
        checks++; if (byte_data !== 8'h41 || byte_rs !== 1'b1) $display("FAIL timeout_resync got %h/%b want 41/1", byte_data, byte_rs); else passed++;
        checks++; if (chars[255:248] !== 8'h41 || cursor !== 5'd1) $display("FAIL timeout_write got %h cur %0d want 41 cur 1", chars[255:248], cursor); else passed++;
        checks++; if (se_cnt !== se0 + 1) $display("FAIL timeout_single got %0d want 1", se_cnt - se0); else passed++;
    endtask

    task automatic test_reset_midbyte;
        int l;
        int bv0;
        strobe(1'b1, 1'b0, 4'h4, l);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (chars !== blank || cursor !== 5'd0) $display("FAIL mid_rst_img got cur %0d want blank cur 0", cursor); else passed++;
        checks++; if (mode4 !== 1'b0 || byte_data !== 8'h00 || byte_rs !== 1'b0) $display("FAIL mid_rst_regs got m4=%b %h/%b want 0 00/0", mode4, byte_data, byte_rs); else passed++;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        bv0 = bv_cnt;
        send_byte(1'b1, 8'h48, l);
        checks++; if (bv_cnt !== bv0 || mode4 !== 1'b0) $display("FAIL boot8_ignore got n=%0d m4=%b want n=%0d m4=0", bv_cnt, mode4, bv0); else passed++;
        strobe(1'b0, 1'b0, 4'h3, l);
        strobe(1'b0, 1'b0, 4'h3, l);
        strobe(1'b0, 1'b0, 4'h3, l);
        strobe(1'b0, 1'b0, 4'h2, l);
        send_byte(1'b1, 8'h48, l);
        checks++; if (mode4 !== 1'b1 || chars[255:248] !== 8'h48 || bv_cnt !== bv0 + 1) $display("FAIL reinit got m4=%b %h n=%0d want 1 48 n=%0d", mode4, chars[255:248], bv_cnt, bv0 + 1); else passed++;
    endtask

    initial begin
        blank = {32{8'h20}};
        repeat (4) @(negedge clk);
        rst = 1'b0;
        #1;
        test_reset();
        test_init();
        test_setup_clear();
        test_data_write();
        test_rw_ignored();
        test_line2_wrap();
        test_timeout();
        test_reset_midbyte();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
